tensor_unit: RTL and testbench
==============================

Name: tensor_unit

Overview:
- Matrix coprocessor directly downstream of the control unit.
- Consumes the level-held LOAD_A, LOAD_B and STORE_TENSOR control lines; answers each with a one-cycle tensor_op_done pulse that releases the control unit's stall.
- Loads two DIMxDIM 16-bit operand matrices from data memory, computes C = A x B sequentially, and writes C back to memory.

Parameters:
- DIM, 2, matrix dimension; N = DIM*DIM elements per matrix
- DATA_W, 16, element and memory data width
- ADDR_W, 16, data memory address width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- load_a  input  1  control line: load matrix A from base_addr
- load_b  input  1  control line: load matrix B from base_addr, then compute C
- store_tensor  input  1  control line: write C to base_addr
- base_addr  input  ADDR_W  tensor base address; sampled when a request is accepted
- mem_rdata  input  DATA_W  read data; valid the cycle after mem_re/mem_addr
- mem_addr  output  ADDR_W  data memory address
- mem_re  output  1  read strobe
- mem_we  output  1  write strobe
- mem_wdata  output  DATA_W  write data
- tensor_op_done  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; A, B, C, accumulator, counters=0.
- Reset values: mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, tensor_op_done=0, busy=0.
- Reset mid-operation aborts immediately; no partial result survives.
- States: IDLE, LOAD, COMPUTE, STORE, DONE, RELEASE.
- IDLE: on a clock edge with any request high, latch base_addr and the op. Priority store_tensor > load_b > load_a.
- Cycle numbering: cycle 0 is the cycle the request is sampled in IDLE.
- LOAD (N+1 cycles):
  - cycles 1..N: mem_re=1, mem_addr=base+i-1.
  - cycles 2..N+1: mem_rdata captured into element i-2 of the target matrix (A or B), row-major.
  - Then: load_a -> DONE; load_b -> COMPUTE.
- COMPUTE (DIM^3 cycles): one MAC per cycle.
  - Loop order: i outer, j middle, k inner.
  - acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j]; on k==DIM-1 the result is written to C[i][j].
  - Products and sums are truncated to DATA_W (mod 2^16, unsigned wrap).
- STORE (N cycles): cycles 1..N: mem_we=1, mem_addr=base+i-1, mem_wdata=C[i-1].
- Address arithmetic wraps mod 2^ADDR_W.
- DONE (1 cycle): tensor_op_done=1.
  - Total done cycle: load_a = N+2; load_b = N+2+DIM^3; store = N+1.
  - With DIM=2: load_a 6, load_b 14, store 5.
- RELEASE: hold until load_a, load_b and store_tensor are all low, then IDLE.
  - Requests still high in the cycle after done must not restart an operation.
  - A new request is accepted no earlier than the cycle after the requests drop.
- Requests deasserted mid-operation do not abort; the op completes and done still pulses.
- Outside its active phase, mem_re/mem_we=0; mem_addr and mem_wdata hold their last value.
- A and B persist across operations; C is overwritten only by COMPUTE.

Test Plan:
- Reset: assert reset low mid-cycle -> all outputs 0 asynchronously, busy=0; release -> remains IDLE with no request.
- load_a with base=0x0010, memory [1,2,3,4]:
  - mem_re in cycles 1-4 at 0x0010..0x0013.
  - A=[1,2,3,4]; done pulse in cycle 6 only.
- Multiply then store:
  - load_b with base=0x0014, memory [5,6,7,8] -> done in cycle 14.
  - store_tensor with base=0x0020 -> writes 19,22,43,50 to 0x0020..0x0023 in cycles 1-4; done in cycle 5.
- Overflow and address wrap:
  - A=[0x0100,0,0,0x0100], B=[0x0100,1,1,0x0100] -> C=[0x0000,0x0100,0x0100,0x0000].
  - Store at base=0xFFFE -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- Handshake: hold load_a high for 3 cycles after done -> no second mem_re burst; busy=1 until load_a falls, then IDLE.
- Reset mid-op: pull reset low in cycle 9 of load_b -> C=0, busy=0, no done pulse; a subsequent store_tensor writes zeros.

Source files
------------

// File: rtl/tensor_unit.sv
// tensor_unit: DIMxDIM matrix coprocessor behind the control unit.
// Loads operand matrices A and B from data memory, multiplies them
// sequentially (one MAC per cycle) into C, and writes C back on request.
//
// Request/done handshake: load_a, load_b and store_tensor are level-held
// by the control unit. A request is taken only in IDLE (priority
// store_tensor > load_b > load_a), base_addr is sampled in that same cycle,
// and the operation always runs to completion even if the request drops.
// Completion is a single-cycle tensor_op_done pulse. The unit then sits in
// RELEASE until every request line is low, so a request still held after
// done can never start a second operation.
module tensor_unit #(
    parameter int DIM    = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              store_tensor,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              tensor_op_done,
    output logic              busy
);

    localparam int N     = DIM * DIM;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int DIM_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CNT_W = $clog2(N + 2) + 1;

    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N + 1);
    localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_STORE,
        S_DONE,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD_A,
        OP_LOAD_B,
        OP_STORE
    } op_t;

    // FSM state kept as a named enum so checkers can bind to it directly.
    state_t            state;
    op_t               op;
    logic [ADDR_W-1:0] base_q;
    // Cycle number within LOAD/STORE; 1 is the first cycle of the phase.
    logic [CNT_W-1:0]  cnt;
    logic [DIM_W-1:0]  ci;
    logic [DIM_W-1:0]  cj;
    logic [DIM_W-1:0]  ck;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mat_a [N];
    logic [DATA_W-1:0] mat_b [N];
    logic [DATA_W-1:0] mat_c [N];

    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    logic [IDX_W-1:0]  c_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  st_idx;
    logic [DATA_W-1:0] mac_prod;
    logic [DATA_W-1:0] mac_sum;

    assign busy = (state != S_IDLE);

    // Row-major element indices and the wrapping multiply-accumulate.
    always_comb begin
        a_idx    = IDX_W'(ci) * IDX_W'(DIM) + IDX_W'(ck);
        b_idx    = IDX_W'(ck) * IDX_W'(DIM) + IDX_W'(cj);
        c_idx    = IDX_W'(ci) * IDX_W'(DIM) + IDX_W'(cj);
        // Read data in LOAD cycle c belongs to the read issued in cycle c-1.
        ld_idx   = IDX_W'(cnt - CNT_TWO);
        st_idx   = IDX_W'(cnt);
        mac_prod = mat_a[a_idx] * mat_b[b_idx];
        mac_sum  = ((ck == '0) ? '0 : acc) + mac_prod;
    end

    // Controller: sequencing, memory strobes, matrix storage and the MAC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            op             <= OP_LOAD_A;
            base_q         <= '0;
            cnt            <= '0;
            ci             <= '0;
            cj             <= '0;
            ck             <= '0;
            acc            <= '0;
            mem_addr       <= '0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
            tensor_op_done <= 1'b0;
            for (int e = 0; e < N; e++) begin
                mat_a[e] <= '0;
                mat_b[e] <= '0;
                mat_c[e] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (store_tensor) begin
                        op        <= OP_STORE;
                        base_q    <= base_addr;
                        cnt       <= CNT_W'(1);
                        mem_we    <= 1'b1;
                        mem_addr  <= base_addr;
                        mem_wdata <= mat_c[0];
                        state     <= S_STORE;
                    end else if (load_b || load_a) begin
                        op       <= load_b ? OP_LOAD_B : OP_LOAD_A;
                        base_q   <= base_addr;
                        cnt      <= CNT_W'(1);
                        mem_re   <= 1'b1;
                        mem_addr <= base_addr;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (cnt >= CNT_TWO) begin
                        if (op == OP_LOAD_B) begin
                            mat_b[ld_idx] <= mem_rdata;
                        end else begin
                            mat_a[ld_idx] <= mem_rdata;
                        end
                    end
                    if (cnt < CNT_N) begin
                        mem_re   <= 1'b1;
                        mem_addr <= base_q + ADDR_W'(cnt);
                    end else begin
                        mem_re <= 1'b0;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (op == OP_LOAD_B) begin
                            ci    <= '0;
                            cj    <= '0;
                            ck    <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            tensor_op_done <= 1'b1;
                            state          <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_COMPUTE: begin
                    acc <= mac_sum;
                    if (ck == DIM_LAST) begin
                        mat_c[c_idx] <= mac_sum;
                        ck <= '0;
                        if (cj == DIM_LAST) begin
                            cj <= '0;
                            if (ci == DIM_LAST) begin
                                ci             <= '0;
                                tensor_op_done <= 1'b1;
                                state          <= S_DONE;
                            end else begin
                                ci <= ci + 1'b1;
                            end
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end else begin
                        ck <= ck + 1'b1;
                    end
                end

                S_STORE: begin
                    if (cnt < CNT_N) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base_q + ADDR_W'(cnt);
                        mem_wdata <= mat_c[st_idx];
                        cnt       <= cnt + CNT_W'(1);
                    end else begin
                        mem_we         <= 1'b0;
                        cnt            <= '0;
                        tensor_op_done <= 1'b1;
                        state          <= S_DONE;
                    end
                end

                S_DONE: begin
                    tensor_op_done <= 1'b0;
                    state          <= S_RELEASE;
                end

                S_RELEASE: begin
                    if (!(load_a || load_b || store_tensor)) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_unit.sv
// tb_tensor_unit: directed bench for tensor_unit (DIM=2).
// Drives the level-held requests, models a one-cycle-latency read memory,
// and checks strobes, addresses, write data and done timing per cycle.
module tb_tensor_unit;

    localparam int DW = 16;
    localparam int AW = 16;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_a = 1'b0;
    logic          load_b = 1'b0;
    logic          store_tensor = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          tensor_op_done;
    logic          busy;

    always #5 clk = ~clk;

    tensor_unit #(.DIM(2), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_a         (load_a),
        .load_b         (load_b),
        .store_tensor   (store_tensor),
        .base_addr      (base_addr),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .tensor_op_done (tensor_op_done),
        .busy           (busy)
    );

    // Read memory: data appears the cycle after mem_re/mem_addr.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    int            re_cyc_q[$];
    logic [AW-1:0] re_addr_q[$];
    int            we_cyc_q[$];
    logic [AW-1:0] we_addr_q[$];
    logic [DW-1:0] we_data_q[$];
    int            done_cyc;
    int            done_cnt;
    logic          busy_at_drop;
    logic          busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic a, input logic b, input logic s, input logic [AW-1:0] base);
        @(negedge clk);
        load_a       = a;
        load_b       = b;
        store_tensor = s;
        base_addr    = base;
    endtask

    task automatic drop_requests();
        load_a       = 1'b0;
        load_b       = 1'b0;
        store_tensor = 1'b0;
    endtask

    // Observes cycles 1..40 of an operation. Requests stay high through
    // cycle done+hold_after and drop in cycle done+hold_after+1.
    task automatic run_op(input int hold_after);
        re_cyc_q.delete();
        re_addr_q.delete();
        we_cyc_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
        done_cyc     = -1;
        done_cnt     = 0;
        busy_at_drop = 1'b0;
        busy_after   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mem_re) begin
                re_cyc_q.push_back(c);
                re_addr_q.push_back(mem_addr);
            end
            if (mem_we) begin
                we_cyc_q.push_back(c);
                we_addr_q.push_back(mem_addr);
                we_data_q.push_back(mem_wdata);
            end
            if (tensor_op_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + hold_after + 1) begin
                busy_at_drop = busy;
                @(negedge clk);
                drop_requests();
            end
            if (done_cyc >= 0 && c == done_cyc + hold_after + 2) busy_after = busy;
            if (done_cyc >= 0 && c == done_cyc + hold_after + 5) break;
        end
        if (done_cyc < 0) begin
            @(negedge clk);
            drop_requests();
        end
    endtask

    task automatic check_op(input string tag, input int exp_done, input logic [AW-1:0] base,
                            input bit is_store);
        logic [AW-1:0] ea;
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_in_release"}, {31'b0, busy_at_drop}, 32'd1);
        check({tag, " busy_after_drop"}, {31'b0, busy_after}, 32'd0);
        if (is_store) begin
            check({tag, " we_count"}, we_cyc_q.size(), 4);
            check({tag, " re_count"}, re_cyc_q.size(), 0);
            for (int i = 0; i < 4; i++) begin
                if (i < we_cyc_q.size()) begin
                    ea = base + AW'(i);
                    check({tag, " we_cycle"}, we_cyc_q[i], i + 1);
                    check({tag, " we_addr"}, {16'b0, we_addr_q[i]}, {16'b0, ea});
                    check({tag, " we_data"}, {16'b0, we_data_q[i]}, {16'b0, exp_q[i]});
                end
            end
        end else begin
            check({tag, " re_count"}, re_cyc_q.size(), 4);
            check({tag, " we_count"}, we_cyc_q.size(), 0);
            for (int i = 0; i < 4; i++) begin
                if (i < re_cyc_q.size()) begin
                    ea = base + AW'(i);
                    check({tag, " re_cycle"}, re_cyc_q[i], i + 1);
                    check({tag, " re_addr"}, {16'b0, re_addr_q[i]}, {16'b0, ea});
                end
            end
        end
    endtask

    task automatic set_exp(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        exp_q.delete();
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int stray_done;
        int stray_busy;

        mem[8'h10] = 16'd1;      mem[8'h11] = 16'd2;
        mem[8'h12] = 16'd3;      mem[8'h13] = 16'd4;
        mem[8'h14] = 16'd5;      mem[8'h15] = 16'd6;
        mem[8'h16] = 16'd7;      mem[8'h17] = 16'd8;
        mem[8'h30] = 16'h0100;   mem[8'h31] = 16'h0000;
        mem[8'h32] = 16'h0000;   mem[8'h33] = 16'h0100;
        mem[8'h34] = 16'h0100;   mem[8'h35] = 16'h0001;
        mem[8'h36] = 16'h0001;   mem[8'h37] = 16'h0100;

        // Reset values, then idle with no request after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst mem_addr", {16'b0, mem_addr}, 32'd0);
        check("rst mem_re", {31'b0, mem_re}, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst mem_wdata", {16'b0, mem_wdata}, 32'd0);
        check("rst done", {31'b0, tensor_op_done}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", {31'b0, busy}, 32'd0);
        check("idle mem_re", {31'b0, mem_re}, 32'd0);

        // A = [1,2,3,4], B = [5,6,7,8], C = A x B = [19,22,43,50].
        issue(1'b1, 1'b0, 1'b0, 16'h0010);
        run_op(0);
        check_op("load_a", 6, 16'h0010, 1'b0);

        issue(1'b0, 1'b1, 1'b0, 16'h0014);
        run_op(0);
        check_op("load_b", 14, 16'h0014, 1'b0);

        set_exp(16'd19, 16'd22, 16'd43, 16'd50);
        issue(1'b0, 1'b0, 1'b1, 16'h0020);
        run_op(0);
        check_op("store", 5, 16'h0020, 1'b1);

        // Reset in cycle 9 of a load_b: outputs clear at once, no done.
        issue(1'b0, 1'b1, 1'b0, 16'h0014);
        stray_done = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (tensor_op_done) stray_done++;
        end
        check("midrst pre_done", stray_done, 0);
        #1;
        reset = 1'b0;
        #1;
        check("midrst mem_addr", {16'b0, mem_addr}, 32'd0);
        check("midrst mem_wdata", {16'b0, mem_wdata}, 32'd0);
        check("midrst mem_re", {31'b0, mem_re}, 32'd0);
        check("midrst mem_we", {31'b0, mem_we}, 32'd0);
        check("midrst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        drop_requests();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        stray_done = 0;
        stray_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (tensor_op_done) stray_done++;
            if (busy) stray_busy++;
        end
        check("midrst post_done", stray_done, 0);
        check("midrst post_busy", stray_busy, 0);

        set_exp(16'd0, 16'd0, 16'd0, 16'd0);
        issue(1'b0, 1'b0, 1'b1, 16'h0040);
        run_op(0);
        check_op("store_zero", 5, 16'h0040, 1'b1);

        // Wrapping products, request held 3 cycles past done, address wrap.
        issue(1'b1, 1'b0, 1'b0, 16'h0030);
        run_op(3);
        check_op("hold_load_a", 6, 16'h0030, 1'b0);

        issue(1'b0, 1'b1, 1'b0, 16'h0034);
        run_op(0);
        check_op("ovf_load_b", 14, 16'h0034, 1'b0);

        set_exp(16'h0000, 16'h0100, 16'h0100, 16'h0000);
        issue(1'b0, 1'b0, 1'b1, 16'hFFFE);
        run_op(0);
        check_op("store_wrap", 5, 16'hFFFE, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
